z80_irq_responder: RTL and testbench
====================================

Name: z80_irq_responder

Overview:
- Peripheral-side Z80 mode-2 daisy-chain interrupt unit: the responder at the far end of the CPU's interrupt-acceptance path.
- Collects up to NUM_SOURCES internal interrupt requests and raises int_n.
- Supplies a vector during the CPU's interrupt-acknowledge cycle.
- Snoops opcode fetches for RETI (ED 4D) to end service and re-open the daisy chain.

Parameters:
- NUM_SOURCES, 4, number of internal request sources (1..8); source 0 has the highest priority.

Ports:
- clk  in  1  system clock; all pin inputs are pre-synchronised to clk.
- reset_n  in  1  asynchronous, active-low reset.
- src_req  in  NUM_SOURCES  one-cycle request pulses, one bit per source.
- vec_base  in  8  vector base; bits [3:1] are replaced by the source index, and bit 0 is forced to 0.
- m1_n  in  1  CPU M1, active low.
- iorq_n  in  1  CPU IORQ, active low.
- rd_n  in  1  CPU RD, active low.
- d_in  in  8  CPU data bus (opcode snoop).
- iei  in  1  daisy-chain enable in.
- ieo  out  1  daisy-chain enable out.
- int_n  out  1  interrupt request to CPU, active low.
- d_out  out  8  vector driven during acknowledge.
- d_oe  out  1  d_out valid/drive enable.
- in_service  out  1  an interrupt of this unit is being serviced.

Behaviour:
- Reset values: int_n=1, ieo=iei (combinational), d_out=0, d_oe=0, in_service=0, pending=0, svc_src=0, RETI FSM=R_IDLE.
- pending[i] is set on src_req[i]. It is cleared only when source i is acknowledged. A request on an already-pending bit is absorbed.
- Main FSM:
  - S_IDLE: go to S_PEND when pending!=0.
  - S_PEND: int_n=0 while iei=1; int_n=1 when iei=0.
  - ack_start: first cycle with m1_n=0 && iorq_n=0, edge-detected against the previous cycle.
  - On ack_start in S_PEND with iei=1:
    - Latch svc_src = lowest set pending index.
    - d_out = {vec_base[7:4], svc_src[2:0], 1'b0}.
    - Clear pending[svc_src].
    - Go to S_ACK.
  - ack_start with iei=0 is ignored.
- S_ACK:
  - d_oe=1 and int_n=1 while m1_n=0 && iorq_n=0.
  - d_oe falls the cycle after either pin deasserts; then go to S_SVC.
- S_SVC:
  - in_service=1 and int_n=1.
  - New requests still set pending, but int_n stays high until service ends.
- RETI FSM:
  - Fetch end: a cycle in which rd_n rises while m1_n was 0 and iorq_n=1 in the previous cycle. d_in is captured from the previous cycle.
  - R_IDLE goes to R_ED on a fetch of 8'hED.
  - In R_ED:
    - fetch of 8'h4D: pulse reti_seen and go to R_IDLE.
    - fetch of 8'hED: stay in R_ED.
    - any other fetch: go to R_IDLE.
  - The RETI FSM runs in every main state.
- reti_seen in S_SVC with iei=1: clear in_service and go to S_PEND if pending!=0, else S_IDLE.
- reti_seen with iei=0 belongs to a higher-priority device and is ignored.
- ieo = iei && !in_service && !(pending!=0 && m1_n==0). Pending requests block lower devices only during M1, so they cannot ripple.
- Reset mid-acknowledge: d_oe drops asynchronously and all state is lost.
- src_req on the same cycle as ack_start: the new bit joins arbitration from the next cycle only.

Optional Feature:
- Macro: IRQ_RESPONDER_MASK_EN.
- With the macro defined:
  - Adds input mask_wr (1) and input mask_in (NUM_SOURCES); mask reg resets to all ones (all masked).
  - A masked source still sets pending but is excluded from int_n generation and from arbitration.
- Without the macro: no mask ports, and all sources are always enabled.

Decomposition:
- Package z80_irq_pkg holds:
  - OPC_ED=8'hED and OPC_RETI2=8'h4D.
  - Enum irq_state_t {S_IDLE,S_PEND,S_ACK,S_SVC}.
  - Enum reti_state_t {R_IDLE,R_ED}.
- Sub-module reti_detector:
  - Inputs: clk, reset_n, m1_n, iorq_n, rd_n, d_in.
  - Output: one-cycle reti_seen.
  - Reusable by other daisy-chain peripherals.

Test Plan:
- Reset with src_req=4'b0100, then release; vec_base=8'h40; drive ack with iei=1.
  - int_n=0 two cycles after the pulse.
  - On ack, d_oe=1 and d_out=8'h44.
  - After ack, in_service=1 and ieo=0.
- Pulse src_req=4'b1010 together, then ack.
  - First d_out=vec_base|8'h02 (source 1), with pending[3] kept.
  - After RETI fetch ED,4D: in_service=0, int_n=0 again.
  - Second ack gives source 3 (|8'h06).
- iei=0 with a pending request.
  - int_n=1 and ack is ignored (d_oe=0).
  - Raise iei: int_n=0 next cycle.
- RETI near-misses while in service.
  - Fetches ED,00,4D leave in_service=1.
  - Fetches ED,ED,4D clear it.
  - ED,4D with iei=0 leaves it set.
- Reset asserted during ack.
  - d_oe=0, int_n=1, in_service=0 immediately; pending is cleared.
- With IRQ_RESPONDER_MASK_EN:
  - After reset, src_req[0] leaves int_n=1.
  - Writing mask_in=4'b1110 drives int_n=0 and ack yields the source-0 vector.

Source files
------------

// File: rtl/z80_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z80_irq_pkg                                                  |
// | Description : Shared opcodes, state encodings and a priority helper for     |
// |               the Z80 mode-2 daisy-chain interrupt responder.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package z80_irq_pkg;

  localparam logic [7:0] OPC_ED    = 8'hED;
  localparam logic [7:0] OPC_RETI2 = 8'h4D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2,
    S_SVC  = 2'd3
  } irq_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_ED   = 1'b1
  } reti_state_t;

  // Index of the lowest set bit; bit 0 is the highest-priority source.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_irq_responder_reti_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reti_detector                                                |
// | Description : Snoops Z80 opcode fetches and pulses reti_seen for one cycle  |
// |               when the sequence ED 4D completes.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reti_detector
  import z80_irq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic [7:0] d_in,
  output logic       reti_seen
);

  reti_state_t r_state;
  reti_state_t w_state_nxt;
  logic        r_m1_prev;
  logic        r_iorq_prev;
  logic        r_rd_prev;
  logic [7:0]  r_d_prev;
  logic        w_fetch_end;
  logic        w_reti;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m1_prev   <= 1'b1;
      r_iorq_prev <= 1'b1;
      r_rd_prev   <= 1'b1;
      r_d_prev    <= 8'h00;
    end else begin
      r_m1_prev   <= m1_n;
      r_iorq_prev <= iorq_n;
      r_rd_prev   <= rd_n;
      r_d_prev    <= d_in;
    end
  end

  // The opcode is taken from the last cycle RD was still low.
  assign w_fetch_end = rd_n && !r_rd_prev && !r_m1_prev && r_iorq_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= R_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reti      = 1'b0;
    if (w_fetch_end) begin
      case (r_state)
        R_IDLE: begin
          if (r_d_prev == OPC_ED) w_state_nxt = R_ED;
        end
        R_ED: begin
          if (r_d_prev == OPC_RETI2) begin
            w_reti      = 1'b1;
            w_state_nxt = R_IDLE;
          end else if (r_d_prev == OPC_ED) begin
            w_state_nxt = R_ED;
          end else begin
            w_state_nxt = R_IDLE;
          end
        end
        default: w_state_nxt = R_IDLE;
      endcase
    end
  end

  assign reti_seen = w_reti;

endmodule
`default_nettype wire

// File: rtl/z80_irq_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z80_irq_responder                                            |
// | Description : Z80 mode-2 daisy-chain interrupt responder. Define            |
// |               IRQ_RESPONDER_MASK_EN to add a per-source mask register.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module z80_irq_responder
  import z80_irq_pkg::*;
#(
  parameter int NUM_SOURCES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] src_req,
  input  logic [7:0]             vec_base,
  input  logic                   m1_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic [7:0]             d_in,
  input  logic                   iei,
`ifdef IRQ_RESPONDER_MASK_EN
  input  logic                   mask_wr,
  input  logic [NUM_SOURCES-1:0] mask_in,
`endif
  output logic                   ieo,
  output logic                   int_n,
  output logic [7:0]             d_out,
  output logic                   d_oe,
  output logic                   in_service
);

  irq_state_t             r_state;
  irq_state_t             w_state_nxt;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [NUM_SOURCES-1:0] w_enable;
  logic [NUM_SOURCES-1:0] w_active;
  logic [NUM_SOURCES-1:0] w_clr;
  logic [2:0]             w_sel;
  logic [2:0]             r_svc_src;
  logic [3:0]             r_vec_hi;
  logic                   r_d_oe;
  logic                   r_int_n;
  logic                   r_ack_prev;
  logic                   w_ack_now;
  logic                   w_ack_start;
  logic                   w_accept;
  logic                   w_reti;
  logic                   w_unused_vec;

  assign w_unused_vec = ^vec_base[3:0];

`ifdef IRQ_RESPONDER_MASK_EN
  logic [NUM_SOURCES-1:0] r_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_mask <= '1;
    else if (mask_wr) r_mask <= mask_in;
  end

  assign w_enable = ~r_mask;
`else
  assign w_enable = '1;
`endif

  // Masked sources still latch but take no part in requests or arbitration.
  assign w_active    = r_pending & w_enable;
  assign w_sel       = lowest_idx(8'(w_active));
  assign w_ack_now   = !m1_n && !iorq_n;
  assign w_ack_start = w_ack_now && !r_ack_prev;

  reti_detector u_reti (
    .clk       (clk),
    .reset_n   (reset_n),
    .m1_n      (m1_n),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .d_in      (d_in),
    .reti_seen (w_reti)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_active) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (w_ack_start && iei && |w_active) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACK;
        end else if (!(|w_active)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        if (m1_n || iorq_n) w_state_nxt = S_SVC;
      end
      S_SVC: begin
        // A RETI seen while iei is low was addressed to a higher device.
        if (w_reti && iei) w_state_nxt = (|w_active) ? S_PEND : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_clr[i] = w_accept && (w_sel == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_svc_src  <= 3'd0;
      r_vec_hi   <= 4'd0;
      r_d_oe     <= 1'b0;
      r_int_n    <= 1'b1;
      r_ack_prev <= 1'b0;
    end else begin
      r_ack_prev <= w_ack_now;
      r_pending  <= (r_pending & ~w_clr) | src_req;
      if (w_accept) begin
        r_svc_src <= w_sel;
        r_vec_hi  <= vec_base[7:4];
      end
      r_d_oe  <= (w_state_nxt == S_ACK);
      r_int_n <= !((w_state_nxt == S_PEND) && iei && (|w_active));
    end
  end

  assign d_out      = {r_vec_hi, r_svc_src, 1'b0};
  assign d_oe       = r_d_oe;
  assign int_n      = r_int_n;
  assign in_service = (r_state == S_SVC);
  // Pending work only blocks lower devices during M1 so it cannot ripple.
  assign ieo        = iei && !in_service && !((|w_active) && !m1_n);

endmodule
`default_nettype wire

// File: tb/tb_z80_irq_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_z80_irq_responder                                         |
// | Description : Self-checking bench for z80_irq_responder; vectors are        |
// |               queued when an acknowledge is driven and popped on d_oe.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_z80_irq_responder;

  localparam int NS = 4;

  logic          clk;
  logic          reset_n;
  logic [NS-1:0] src_req;
  logic [7:0]    vec_base;
  logic          m1_n;
  logic          iorq_n;
  logic          rd_n;
  logic [7:0]    d_in;
  logic          iei;
  logic          ieo;
  logic          int_n;
  logic [7:0]    d_out;
  logic          d_oe;
  logic          in_service;
`ifdef IRQ_RESPONDER_MASK_EN
  logic          mask_wr;
  logic [NS-1:0] mask_in;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  z80_irq_responder #(.NUM_SOURCES(NS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_req    (src_req),
    .vec_base   (vec_base),
    .m1_n       (m1_n),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .d_in       (d_in),
    .iei        (iei),
`ifdef IRQ_RESPONDER_MASK_EN
    .mask_wr    (mask_wr),
    .mask_in    (mask_in),
`endif
    .ieo        (ieo),
    .int_n      (int_n),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NS-1:0] bits);
    src_req = bits;
    tick();
    src_req = '0;
  endtask

  task automatic fetch(input logic [7:0] op);
    m1_n  = 1'b0;
    rd_n  = 1'b0;
    d_in  = op;
    tick();
    tick();
    m1_n  = 1'b1;
    rd_n  = 1'b1;
    tick();
    d_in  = 8'h00;
  endtask

  // Drives one acknowledge cycle; the expected vector goes to the scoreboard.
  task automatic do_ack(input bit expect_vec, input logic [7:0] vec);
    bit seen;
    seen = 1'b0;
    if (expect_vec) exp_q.push_back(vec);
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_oe && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) check("spurious_oe", d_oe, 1'b0);
        else                   check("ack_vec", d_out, exp_q.pop_front());
        check("ack_int_n", int_n, 1'b1);
      end
    end
    if (expect_vec && !seen) begin
      check("ack_timeout", d_oe, 1'b1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (!expect_vec) check("ack_ignored_oe", seen, 1'b0);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    check("ack_oe_drop", d_oe, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    src_req  = 4'b0100;
    vec_base = 8'h40;
    m1_n     = 1'b1;
    iorq_n   = 1'b1;
    rd_n     = 1'b1;
    d_in     = 8'h00;
    iei      = 1'b1;
`ifdef IRQ_RESPONDER_MASK_EN
    mask_wr  = 1'b0;
    mask_in  = '0;
`endif
    repeat (3) tick();
    check("rst_int_n", int_n, 1'b1);
    check("rst_d_out", d_out, 8'h00);
    check("rst_d_oe", d_oe, 1'b0);
    check("rst_in_service", in_service, 1'b0);
    check("rst_ieo_hi", ieo, 1'b1);
    iei = 1'b0;
    #1;
    check("rst_ieo_lo", ieo, 1'b0);
    iei = 1'b1;
    src_req = '0;
    reset_n = 1'b1;
    repeat (2) tick();
    check("no_req_after_rst", int_n, 1'b1);

`ifdef IRQ_RESPONDER_MASK_EN
    pulse(4'b0001);
    repeat (3) tick();
    check("mask_blocks_int", int_n, 1'b1);
    mask_in = 4'b1110;
    mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
    tick();
    check("mask_unmask_int", int_n, 1'b0);
    do_ack(1'b1, 8'h40);
    fetch(8'hED);
    fetch(8'h4D);
    check("mask_reti", in_service, 1'b0);
    mask_in = 4'b0000;
    mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
`endif

    // Single source, latency and vector
    pulse(4'b0100);
    check("t1_int_n_c1", int_n, 1'b1);
    tick();
    check("t1_int_n_c2", int_n, 1'b0);
    do_ack(1'b1, 8'h44);
    check("t1_in_service", in_service, 1'b1);
    check("t1_ieo", ieo, 1'b0);
    fetch(8'hED);
    fetch(8'h4D);
    check("t1_reti", in_service, 1'b0);
    tick();
    check("t1_idle_int_n", int_n, 1'b1);

    // Two sources: priority order, remainder kept across service
    pulse(4'b1010);
    tick();
    check("t2_int_n", int_n, 1'b0);
    do_ack(1'b1, 8'h42);
    check("t2_in_service", in_service, 1'b1);
    check("t2_svc_int_n", int_n, 1'b1);
    fetch(8'hED);
    fetch(8'h4D);
    check("t2_reti_svc", in_service, 1'b0);
    check("t2_reraise", int_n, 1'b0);
    do_ack(1'b1, 8'h46);
    fetch(8'hED);
    fetch(8'h4D);
    check("t2_reti2", in_service, 1'b0);
    tick();
    check("t2_empty", int_n, 1'b1);

    // Daisy-chain disabled from above
    iei = 1'b0;
    pulse(4'b0001);
    repeat (2) tick();
    check("t3_iei0_int_n", int_n, 1'b1);
    do_ack(1'b0, 8'h00);
    check("t3_iei0_after_ack", int_n, 1'b1);
    iei = 1'b1;
    tick();
    check("t3_iei1_int_n", int_n, 1'b0);
    check("t3_ieo_no_m1", ieo, 1'b1);
    m1_n = 1'b0;
    #1;
    check("t3_ieo_m1", ieo, 1'b0);
    m1_n = 1'b1;
    do_ack(1'b1, 8'h40);

    // RETI near-misses
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    check("t4_ed_00_4d", in_service, 1'b1);
    iei = 1'b0;
    fetch(8'hED);
    fetch(8'h4D);
    check("t4_reti_iei0", in_service, 1'b1);
    iei = 1'b1;
    fetch(8'hED);
    fetch(8'hED);
    fetch(8'h4D);
    check("t4_ed_ed_4d", in_service, 1'b0);

    // Reset in the middle of an acknowledge
    pulse(4'b1010);
    tick();
    exp_q.push_back(8'h42);
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    tick();
    if (d_oe) begin
      check("t5_ack_vec", d_out, exp_q.pop_front());
    end else begin
      check("t5_ack_oe", d_oe, 1'b1);
      void'(exp_q.pop_front());
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_d_oe", d_oe, 1'b0);
    check("t5_rst_int_n", int_n, 1'b1);
    check("t5_rst_in_service", in_service, 1'b0);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("t5_pending_gone", int_n, 1'b1);
    m1_n = 1'b0;
    #1;
    check("t5_ieo_m1", ieo, 1'b1);
    m1_n = 1'b1;
    tick();

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
